// File: rtl/tiny_alu_pkg.sv
// Shared opcode constants and issuer FSM state type for the tiny ALU command path.
package tiny_alu_pkg;

    localparam int unsigned OPCODE_BITS = 3;

    localparam logic [OPCODE_BITS-1:0] NOP_OP = 3'd0;
    localparam logic [OPCODE_BITS-1:0] ADD_OP = 3'd1;
    localparam logic [OPCODE_BITS-1:0] AND_OP = 3'd2;
    localparam logic [OPCODE_BITS-1:0] XOR_OP = 3'd3;
    localparam logic [OPCODE_BITS-1:0] MUL_OP = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } issuer_state_t;

endpackage

// File: rtl/tiny_alu_cmd_issuer_if.sv
// Command, ALU and response signal bundle of the command issuer.
interface tiny_alu_cmd_issuer_if
    import tiny_alu_pkg::*;
#(
    parameter int unsigned INPUT_DATA_BITS = 8,
    parameter int unsigned FIFO_DEPTH      = 4
);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    logic                         cmd_valid_i;
    logic                         cmd_ready_o;
    logic [INPUT_DATA_BITS-1:0]   cmd_a_i;
    logic [INPUT_DATA_BITS-1:0]   cmd_b_i;
    logic [OPCODE_BITS-1:0]       cmd_opcode_i;
    logic [INPUT_DATA_BITS-1:0]   alu_a_o;
    logic [INPUT_DATA_BITS-1:0]   alu_b_o;
    logic [OPCODE_BITS-1:0]       alu_opcode_o;
    logic                         alu_start_o;
    logic [2*INPUT_DATA_BITS-1:0] alu_result_i;
    logic                         alu_done_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [2*INPUT_DATA_BITS-1:0] rsp_result_o;
    logic                         rsp_error_o;
    logic [LevelW-1:0]            cmd_level_o;

    // Issuer side.
    modport master (
        input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_opcode_i,
        input  alu_result_i, alu_done_i, rsp_ready_i,
        output cmd_ready_o, alu_a_o, alu_b_o, alu_opcode_o, alu_start_o,
        output rsp_valid_o, rsp_result_o, rsp_error_o, cmd_level_o
    );

    // Environment side: command source, ALU and response sink.
    modport slave (
        output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_opcode_i,
        output alu_result_i, alu_done_i, rsp_ready_i,
        input  cmd_ready_o, alu_a_o, alu_b_o, alu_opcode_o, alu_start_o,
        input  rsp_valid_o, rsp_result_o, rsp_error_o, cmd_level_o
    );

endinterface

// File: rtl/tiny_alu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module tiny_alu_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (PtrW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(do_push);
        rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
        level_d  = level_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tiny_alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time on start/done and returns
// each result (or a timeout error) on a valid/ready response port.
module tiny_alu_cmd_issuer
    import tiny_alu_pkg::*;
#(
    parameter int unsigned INPUT_DATA_BITS = 8,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input logic                   clk_i,
    input logic                   reset_i,
    tiny_alu_cmd_issuer_if.master bus
);
    localparam int unsigned CmdW   = OPCODE_BITS + 2 * INPUT_DATA_BITS;
    localparam int unsigned ResW   = 2 * INPUT_DATA_BITS;
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CmdW-1:0]            fifo_wdata, fifo_rdata;
    logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [LevelW-1:0]          fifo_level;
    logic [INPUT_DATA_BITS-1:0] head_a, head_b;
    logic [OPCODE_BITS-1:0]     head_op;

    issuer_state_t              state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       start_q, start_d;
    logic [INPUT_DATA_BITS-1:0] a_q, a_d, b_q, b_d;
    logic [OPCODE_BITS-1:0]     op_q, op_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [ResW-1:0]            rsp_result_q, rsp_result_d;
    logic                       rsp_error_q, rsp_error_d;

    assign fifo_wdata = {bus.cmd_opcode_i, bus.cmd_a_i, bus.cmd_b_i};
    assign fifo_push  = bus.cmd_valid_i && !fifo_full;
    assign {head_op, head_a, head_b} = fifo_rdata;

    tiny_alu_cmd_fifo #(
        .WIDTH (CmdW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        fifo_pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_d      = head_a;
                    b_d      = head_b;
                    op_d     = head_op;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // done seen on the first BUSY edge still belongs to the previous command
                if (cnt_q != '0 && bus.alu_done_i) begin
                    rsp_result_d = bus.alu_result_i;
                    rsp_error_d  = 1'b0;
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (cnt_q == CntLast) begin
                    rsp_result_d = '0;
                    rsp_error_d  = 1'b1;
                    start_d      = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign bus.cmd_ready_o  = !fifo_full;
    assign bus.cmd_level_o  = fifo_level;
    assign bus.alu_a_o      = a_q;
    assign bus.alu_b_o      = b_q;
    assign bus.alu_opcode_o = op_q;
    assign bus.alu_start_o  = start_q;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_result_o = rsp_result_q;
    assign bus.rsp_error_o  = rsp_error_q;

endmodule

// File: tb/tb_tiny_alu_cmd_issuer.sv
// Randomised and directed bench for tiny_alu_cmd_issuer against a queue-based
// reference model, with a behavioural ALU whose done stays high until the next start.
module tb_tiny_alu_cmd_issuer;
    import tiny_alu_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tiny_alu_cmd_issuer_if #(
        .INPUT_DATA_BITS (DW),
        .FIFO_DEPTH      (DEPTH)
    ) bus ();

    tiny_alu_cmd_issuer #(
        .INPUT_DATA_BITS (DW),
        .FIFO_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ALU stand-in: answers one edge after start rises; done and result are sticky.
    logic stub_start_prev;
    always @(posedge clk) begin
        if (reset) begin
            bus.alu_done_i   <= 1'b0;
            bus.alu_result_i <= '0;
            stub_start_prev  <= 1'b0;
        end else begin
            stub_start_prev <= bus.alu_start_o;
            if (bus.alu_start_o && !stub_start_prev) begin
                bus.alu_done_i <= (bus.alu_opcode_o <= MUL_OP);
                case (bus.alu_opcode_o)
                    ADD_OP:  bus.alu_result_i <= {8'h00, bus.alu_a_o} + {8'h00, bus.alu_b_o};
                    AND_OP:  bus.alu_result_i <= {8'h00, bus.alu_a_o & bus.alu_b_o};
                    XOR_OP:  bus.alu_result_i <= {8'h00, bus.alu_a_o ^ bus.alu_b_o};
                    MUL_OP:  bus.alu_result_i <= bus.alu_a_o * bus.alu_b_o;
                    NOP_OP:  bus.alu_result_i <= 16'h0000;
                    default: bus.alu_result_i <= 16'hDEAD;
                endcase
            end
        end
    end

    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [15:0] res, output logic err);
        int unsigned ua = a;
        int unsigned ub = b;
        err = 1'b0;
        case (op)
            3'd0:    res = 16'd0;
            3'd1:    res = 16'(ua + ub);
            3'd2:    res = 16'(ua & ub);
            3'd3:    res = 16'(ua ^ ub);
            3'd4:    res = 16'(ua * ub);
            default: begin res = 16'd0; err = 1'b1; end
        endcase
    endfunction

    logic [15:0] exp_res_q[$];
    logic        exp_err_q[$];
    int          rsp_count = 0;

    // Scoreboard: records accepted commands, checks every response handshake and
    // that a stalled response does not change.
    initial begin
        bit          hold_prev = 1'b0;
        logic [15:0] hold_res  = '0;
        logic        hold_err  = 1'b0;
        logic [15:0] r;
        logic        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_res_q.delete();
                exp_err_q.delete();
                hold_prev = 1'b0;
            end else begin
                if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                    model(bus.cmd_opcode_i, bus.cmd_a_i, bus.cmd_b_i, r, e);
                    exp_res_q.push_back(r);
                    exp_err_q.push_back(e);
                end
                if (hold_prev) begin
                    check_eq("hold_result", bus.rsp_result_o, hold_res);
                    check_eq("hold_error", bus.rsp_error_o, hold_err);
                end
                if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                    check_eq("rsp_expected", exp_res_q.size() != 0, 1);
                    if (exp_res_q.size() != 0) begin
                        check_eq("rsp_result", bus.rsp_result_o, exp_res_q.pop_front());
                        check_eq("rsp_error", bus.rsp_error_o, exp_err_q.pop_front());
                        rsp_count++;
                    end
                end
                hold_prev = bus.rsp_valid_o && !bus.rsp_ready_i;
                hold_res  = bus.rsp_result_o;
                hold_err  = bus.rsp_error_o;
            end
        end
    end

    // Call from just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_opcode_i = op;
        bus.cmd_a_i      = a;
        bus.cmd_b_i      = b;
        @(negedge clk);
        while (!bus.cmd_ready_o && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited != 0) check_eq("send_ready", bus.cmd_ready_o, 1);
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_res_q.size() != 0 || bus.rsp_valid_o) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", exp_res_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int t_start;
        int t_valid;
        bit rnd_done;
        logic [2:0] op;

        bus.cmd_valid_i  = 1'b0;
        bus.cmd_a_i      = '0;
        bus.cmd_b_i      = '0;
        bus.cmd_opcode_i = '0;
        bus.rsp_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", bus.cmd_ready_o, 1);
        check_eq("rst_level", bus.cmd_level_o, 0);
        check_eq("rst_start", bus.alu_start_o, 0);
        check_eq("rst_alu_a", bus.alu_a_o, 0);
        check_eq("rst_alu_b", bus.alu_b_o, 0);
        check_eq("rst_alu_op", bus.alu_opcode_o, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
        check_eq("rst_rsp_result", bus.rsp_result_o, 0);
        check_eq("rst_rsp_error", bus.rsp_error_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single ADD: latency from accept to rsp_valid.
        send(ADD_OP, 8'h12, 8'h34);
        t_valid = -1;
        for (int i = 0; i < 20 && t_valid < 0; i++) begin
            @(negedge clk);
            if (i == 1) check_eq("add_start_high", bus.alu_start_o, 1);
            if (bus.rsp_valid_o) begin
                t_valid = i;
                check_eq("add_result", bus.rsp_result_o, 16'h0046);
                check_eq("add_error", bus.rsp_error_o, 0);
            end
        end
        check_eq("add_latency", t_valid, 3);
        @(posedge clk);
        #1 drain(50);

        // Ordered sequence.
        send(MUL_OP, 8'hFF, 8'hFF);
        send(XOR_OP, 8'hA5, 8'h5A);
        send(AND_OP, 8'hF0, 8'h3C);
        drain(100);

        // Five back-to-back with the response port stalled.
        bus.rsp_ready_i = 1'b0;
        base = rsp_count;
        for (int i = 0; i < 5; i++) send(3'(i % 5), 8'(8'h10 + i), 8'(8'h20 + 3 * i));
        @(negedge clk);
        check_eq("full_level", bus.cmd_level_o, DEPTH);
        check_eq("full_cmd_ready", bus.cmd_ready_o, 0);
        check_eq("full_rsp_valid", bus.rsp_valid_o, 1);
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b1;
        drain(200);
        check_eq("full_rsp_count", rsp_count - base, 5);

        // Timeout: error exactly TMO cycles after BUSY entry, then normal service.
        send(3'd7, 8'h01, 8'h02);
        t_start = -1;
        t_valid = -1;
        for (int i = 0; i < 100 && t_valid < 0; i++) begin
            @(negedge clk);
            if (t_start < 0 && bus.alu_start_o) t_start = i;
            if (bus.rsp_valid_o) begin
                t_valid = i;
                check_eq("tmo_error", bus.rsp_error_o, 1);
                check_eq("tmo_result", bus.rsp_result_o, 0);
            end
        end
        check_eq("tmo_latency", t_valid - t_start, TMO);
        @(posedge clk);
        #1 send(ADD_OP, 8'h01, 8'h01);
        drain(50);

        // Reset during BUSY with commands queued.
        send(3'd7, 8'h00, 8'h00);
        send(ADD_OP, 8'h05, 8'h06);
        send(ADD_OP, 8'h07, 8'h08);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_start", bus.alu_start_o, 0);
        check_eq("mid_rst_level", bus.cmd_level_o, 0);
        check_eq("mid_rst_rsp_valid", bus.rsp_valid_o, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        base = rsp_count;
        send(ADD_OP, 8'h03, 8'h04);
        drain(50);
        check_eq("post_rst_count", rsp_count - base, 1);

        // Random commands with random response back-pressure.
        base = rsp_count;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    op = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 4));
                    send(op, 8'($urandom), 8'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.rsp_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.rsp_ready_i = 1'b1;
        drain(2000);
        check_eq("rand_rsp_count", rsp_count - base, 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
